// File: rtl/ddr_line_writer.sv
// ddr_line_writer: takes one assembled 128-bit line and its DDR address, and
// issues it as a single BL8 write on a MIG-style user interface.
//
// The command channel (app_en/app_rdy) and the write-data channel
// (app_wdf_wren/app_wdf_rdy) are handshaken independently. Either may complete
// first, or both may complete in the same cycle. A one-cycle done pulse tells
// the upstream sequencer it can start filling the next line.
//
// Optional feature, enabled by defining DDR_WR_TIMEOUT_EN: a watchdog abandons
// a transfer that is still pending after TIMEOUT_CYC cycles in XFER and sets
// the sticky err flag. Without the macro, XFER waits indefinitely and err is
// tied to 0.

module ddr_line_writer #(
    parameter int ADDR_W      = 28,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              calib_done,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [127:0]      req_data,

    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [127:0]      app_wdf_data,
    output logic [15:0]       app_wdf_mask,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,

    output logic              busy,
    output logic              done,
    output logic [15:0]       wr_count,
    output logic              err
);

    // The watchdog compares against TIMEOUT_CYC-1, so at least two cycles are
    // needed for a meaningful limit.
    if (TIMEOUT_CYC < 2) begin : g_timeout_check
        $error("ddr_line_writer: TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Per-channel "already accepted" flags for the current line.
    logic cmd_ok;
    logic dat_ok;

    logic accept;
    logic cmd_acc;
    logic dat_acc;
    logic both_done;
    logic tmo_hit;

    // The three low address bits are cleared to force BL8 alignment.
    logic addr_unused;
    assign addr_unused = ^req_addr[2:0];

    // Only write commands with every byte enabled are ever issued.
    assign app_cmd      = 3'b000;
    assign app_wdf_mask = 16'h0000;

    // A BL8 line is a single 128-bit beat, so every beat is also the last one.
    assign app_wdf_end  = app_wdf_wren;

    assign req_ready = (state == IDLE) && calib_done;
    assign accept    = req_valid && req_ready;

    // app_en and app_wdf_wren are only ever high in XFER, so these accept
    // terms cannot fire in any other state.
    assign cmd_acc   = app_en && app_rdy;
    assign dat_acc   = app_wdf_wren && app_wdf_rdy;

    // Both channels finished, counting this cycle's accepts.
    assign both_done = (cmd_ok || cmd_acc) && (dat_ok || dat_acc);

`ifdef DDR_WR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt;

    // A successful completion in the limit cycle takes priority over the
    // timeout.
    assign tmo_hit = (state == XFER) && !both_done &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Watchdog: cleared on entry to XFER, counts every cycle spent in XFER.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == XFER) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (tmo_hit) begin
            err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    // Line-write sequencer: capture in IDLE, run both handshakes in XFER,
    // then pulse done for one cycle in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            app_addr     <= '0;
            app_wdf_data <= '0;
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
            cmd_ok       <= 1'b0;
            dat_ok       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wr_count     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        app_addr     <= {req_addr[ADDR_W-1:3], 3'b000};
                        app_wdf_data <= req_data;
                        cmd_ok       <= 1'b0;
                        dat_ok       <= 1'b0;
                        app_en       <= 1'b1;
                        app_wdf_wren <= 1'b1;
                        busy         <= 1'b1;
                        state        <= XFER;
                    end
                end

                XFER: begin
                    if (cmd_acc) begin
                        cmd_ok <= 1'b1;
                        app_en <= 1'b0;
                    end
                    if (dat_acc) begin
                        dat_ok       <= 1'b1;
                        app_wdf_wren <= 1'b0;
                    end
                    if (both_done) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        wr_count <= wr_count + 16'd1;
                        state    <= DONE;
                    end else if (tmo_hit) begin
                        // Abandon the line: withdraw both requests and still
                        // release the upstream sequencer, but do not count it.
                        app_en       <= 1'b0;
                        app_wdf_wren <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_line_writer.sv
// tb_ddr_line_writer: directed test of ddr_line_writer with hand-computed
// expected values. Inputs are driven and outputs sampled 1 ns after each
// rising clock edge.

module tb_ddr_line_writer;

    localparam int ADDR_W = 28;

    logic              clk = 1'b0;
    logic              reset;
    logic              calib_done;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [127:0]      req_data;
    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [127:0]      app_wdf_data;
    logic [15:0]       app_wdf_mask;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy;
    logic              busy;
    logic              done;
    logic [15:0]       wr_count;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] D1 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    localparam logic [127:0] D2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D3 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    localparam logic [127:0] D4 = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
    localparam logic [127:0] D5 = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;

    always #5 clk = ~clk;

    ddr_line_writer #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .calib_done   (calib_done),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .app_addr     (app_addr),
        .app_cmd      (app_cmd),
        .app_en       (app_en),
        .app_rdy      (app_rdy),
        .app_wdf_data (app_wdf_data),
        .app_wdf_mask (app_wdf_mask),
        .app_wdf_wren (app_wdf_wren),
        .app_wdf_end  (app_wdf_end),
        .app_wdf_rdy  (app_wdf_rdy),
        .busy         (busy),
        .done         (done),
        .wr_count     (wr_count),
        .err          (err)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge; the caller ensures req_ready.
    task automatic send(input logic [ADDR_W-1:0] addr, input logic [127:0] data);
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish by 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int en_cnt, wr_cnt, end_cnt, done_cnt, done_at, data_bad, gate_bad;
        int first, last, gap_bad;

        reset       = 1'b0;
        calib_done  = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_data    = '0;
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_eq("rst_app_en",   app_en,       0);
        check_eq("rst_wren",     app_wdf_wren, 0);
        check_eq("rst_busy",     busy,         0);
        check_eq("rst_done",     done,         0);
        check_eq("rst_err",      err,          0);
        check_eq("rst_wr_count", wr_count,     0);
        check_eq("rst_app_addr", app_addr,     0);
        check_eq("rst_wdf_data", app_wdf_data, 0);
        check_eq("rst_ready",    req_ready,    0);
        reset = 1'b1;
        tick();

        // ---------------- basic write ----------------
        calib_done  = 1'b1;
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        #1;
        check_eq("basic_ready_idle", req_ready, 1);
        send(28'h0000013, D1);
        check_eq("basic_en_c1",   app_en,       1);
        check_eq("basic_wren_c1", app_wdf_wren, 1);
        check_eq("basic_end_c1",  app_wdf_end,  1);
        check_eq("basic_addr",    app_addr,     28'h0000010);
        check_eq("basic_data",    app_wdf_data, D1);
        check_eq("basic_cmd",     app_cmd,      0);
        check_eq("basic_mask",    app_wdf_mask, 0);
        check_eq("basic_busy_c1", busy,         1);
        check_eq("basic_ready_c1", req_ready,   0);
        check_eq("basic_done_c1", done,         0);
        tick();
        check_eq("basic_done_c2", done,         1);
        check_eq("basic_en_c2",   app_en,       0);
        check_eq("basic_wren_c2", app_wdf_wren, 0);
        check_eq("basic_busy_c2", busy,         0);
        check_eq("basic_ready_c2", req_ready,   0);
        check_eq("basic_count",   wr_count,     1);
        tick();
        check_eq("basic_done_c3", done,         0);
        check_eq("basic_ready_c3", req_ready,   1);

        // ---------------- data before command ----------------
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b1;
        send(28'h0000027, D2);
        check_eq("dbc_addr", app_addr, 28'h0000020);
        en_cnt = 0; wr_cnt = 0; end_cnt = 0; done_cnt = 0; done_at = 0;
        for (int i = 1; i <= 12; i++) begin
            app_rdy = (i >= 6);
            if (app_en)       en_cnt++;
            if (app_wdf_wren) wr_cnt++;
            if (app_wdf_end)  end_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            tick();
        end
        check_eq("dbc_en_cycles",   en_cnt,   6);
        check_eq("dbc_wren_cycles", wr_cnt,   1);
        check_eq("dbc_end_cycles",  end_cnt,  1);
        check_eq("dbc_done_pulses", done_cnt, 1);
        check_eq("dbc_done_at",     done_at,  7);
        check_eq("dbc_count",       wr_count, 2);

        // ---------------- command before data ----------------
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b0;
        send(28'h0000100, D3);
        en_cnt = 0; wr_cnt = 0; end_cnt = 0; done_cnt = 0; done_at = 0; data_bad = 0;
        for (int i = 1; i <= 8; i++) begin
            app_wdf_rdy = (i >= 4);
            req_data    = ~req_data;
            if (app_en)       en_cnt++;
            if (app_wdf_wren) wr_cnt++;
            if (app_wdf_end)  end_cnt++;
            if (busy && app_wdf_data !== D3) data_bad++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            tick();
        end
        check_eq("cbd_en_cycles",   en_cnt,   1);
        check_eq("cbd_wren_cycles", wr_cnt,   4);
        check_eq("cbd_end_cycles",  end_cnt,  4);
        check_eq("cbd_data_stable", data_bad, 0);
        check_eq("cbd_data_final",  app_wdf_data, D3);
        check_eq("cbd_done_at",     done_at,  5);
        check_eq("cbd_count",       wr_count, 3);

        // ---------------- calibration gate and back-to-back ----------------
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        calib_done  = 1'b0;
        req_valid   = 1'b1;
        req_addr    = 28'h0ABCDEF;
        req_data    = D4;
        gate_bad    = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (app_en || busy || req_ready) gate_bad++;
            tick();
        end
        check_eq("gate_no_activity", gate_bad, 0);
        check_eq("gate_count",       wr_count, 3);
        calib_done = 1'b1;
        done_cnt = 0; first = 0; last = 0; gap_bad = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 10) req_valid = 1'b0;
            if (done) begin
                done_cnt++;
                if (first == 0) first = i;
                else if (i - last != 3) gap_bad++;
                last = i;
            end
        end
        check_eq("b2b_done_pulses", done_cnt, 4);
        check_eq("b2b_first_done",  first,    2);
        check_eq("b2b_last_done",   last,     11);
        check_eq("b2b_gap",         gap_bad,  0);
        check_eq("b2b_count",       wr_count, 7);
        check_eq("b2b_addr",        app_addr, 28'h0ABCDE8);

        // ---------------- reset mid-transaction ----------------
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b0;
        send(28'h0000055, D5);
        tick();
        check_eq("rmid_en_before",   app_en, 1);
        check_eq("rmid_busy_before", busy,   1);
        reset = 1'b0;
        #1;
        check_eq("rmid_en_async",   app_en,       0);
        check_eq("rmid_wren_async", app_wdf_wren, 0);
        check_eq("rmid_busy_async", busy,         0);
        tick();
        check_eq("rmid_done_in_rst", done, 0);
        reset = 1'b1;
        tick();
        check_eq("rmid_ready_after", req_ready, 1);
        check_eq("rmid_count_after", wr_count,  0);
        check_eq("rmid_done_after",  done,      0);

`ifdef DDR_WR_TIMEOUT_EN
        // ---------------- watchdog timeout ----------------
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b1;
        send(28'h0000200, D2);
        en_cnt = 0; done_cnt = 0; done_at = 0;
        for (int i = 1; i <= 20; i++) begin
            if (app_en) en_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            tick();
        end
        check_eq("tmo_en_cycles",   en_cnt,   16);
        check_eq("tmo_done_pulses", done_cnt, 1);
        check_eq("tmo_done_at",     done_at,  17);
        check_eq("tmo_err",         err,      1);
        check_eq("tmo_count",       wr_count, 0);
        app_rdy = 1'b1;
        send(28'h0000300, D3);
        tick();
        check_eq("tmo_next_done",  done,     1);
        check_eq("tmo_next_count", wr_count, 1);
        check_eq("tmo_err_sticky", err,      1);
        tick();
`else
        check_eq("no_tmo_err", err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
